// File: rtl/mem_pkg.sv
// mem_pkg: funct3 encodings, FSM state type, the data-memory command payload and
// access-size helpers shared by the MEM pipeline stage.
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;
    localparam int unsigned RD_W = 5;
    localparam int unsigned F3_W = 3;

    // RV32I load encodings
    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    // RV32I store encodings
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SH  = 3'b001;
    localparam logic [F3_W-1:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // Request held stable on the data-memory port while an access is outstanding
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dmem_cmd_t;

    // Access size of a load; unknown encodings behave as a word load
    function automatic size_t load_size(input logic [F3_W-1:0] f3);
        size_t sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Access size of a store; unknown encodings behave as a word store
    function automatic size_t store_size(input logic [F3_W-1:0] f3);
        size_t sz;
        case (f3)
            F3_SB:   sz = SZ_BYTE;
            F3_SH:   sz = SZ_HALF;
            F3_SW:   sz = SZ_WORD;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] addr_lo);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

    // Byte enables for a store of the given size at the given lane
    function automatic logic [BE_W-1:0] store_be(input size_t sz, input logic [1:0] addr_lo);
        logic [BE_W-1:0] be;
        case (sz)
            SZ_BYTE: be = BE_W'(1) << addr_lo;
            SZ_HALF: be = BE_W'(3) << addr_lo;
            default: be = {BE_W{1'b1}};
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the size can occupy
    function automatic logic [XLEN-1:0] store_wdata(input size_t sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/halfword lane of a raw read word and
// sign- or zero-extends it according to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [F3_W-1:0] funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select: byte by addr[1:0], halfword by addr[1]
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'b00:   byte_sel = rdata_i[7:0];
            2'b01:   byte_sel = rdata_i[15:8];
            2'b10:   byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension; unknown encodings pass the full word
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Issues loads/stores over a req/ack
// data-memory handshake, extends load data, stalls upstream while an access is
// outstanding and registers the MEM/WB outputs.
// Optional feature: define MEM_STAGE_TIMEOUT_EN to add a watchdog that aborts an
// access after TIMEOUT_CYCLES busy cycles without an ack and pulses bus_err_o.
module mem_access_stage
    import mem_pkg::*;
`ifdef MEM_STAGE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_alu_result_i,
    input  logic [XLEN-1:0] ex_store_data_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_mem_write_i,
    input  logic [F3_W-1:0] ex_funct3_i,
    input  logic [RD_W-1:0] ex_rd_i,
    input  logic            ex_reg_write_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [BE_W-1:0] dmem_be_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic            mem_read_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic            wb_reg_write_o,
    output logic            misalign_err_o,
    output logic            bus_err_o
);

    mem_state_t      state_q, state_d;
    dmem_cmd_t       cmd_q, cmd_d;
    logic            req_q, req_d;

    // Latched copy of the accepted memory instruction
    logic [XLEN-1:0] ea_q, ea_d;
    logic [F3_W-1:0] f3_q, f3_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            rw_q, rw_d;
    logic            ld_q, ld_d;

    // MEM/WB register
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mdata_q, mdata_d;
    logic            mread_q, mread_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic            wb_rw_q, wb_rw_d;
    logic            mis_q, mis_d;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_q, berr_d;
`endif

    logic            ex_is_load;
    logic            ex_is_mem;
    logic            ex_mis;
    size_t           ex_size;
    logic [XLEN-1:0] ext_data;

    // Decode of the instruction presented by EX/MEM; both flags set means load
    always_comb begin
        ex_is_load = ex_mem_read_i;
        ex_is_mem  = ex_mem_read_i | ex_mem_write_i;
        ex_size    = ex_is_load ? load_size(ex_funct3_i) : store_size(ex_funct3_i);
        ex_mis     = ex_is_mem & is_misaligned(ex_size, ex_alu_result_i[1:0]);
    end

    load_extend u_load_extend (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (ea_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (ext_data)
    );

    // Freeze upstream while a fresh access is being accepted or is still pending
    assign stall_o = ((state_q == IDLE) && ex_valid_i && ex_is_mem && !ex_mis) ||
                     ((state_q == BUSY) && !dmem_ack_i);

    // Next-state and MEM/WB update
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        req_d      = req_q;
        ea_d       = ea_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        ld_d       = ld_q;
        wb_valid_d = 1'b0;
        alu_d      = alu_q;
        mdata_d    = mdata_q;
        mread_d    = mread_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        mis_d      = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d      = cnt_q;
        berr_d     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (!ex_is_mem) begin
                        wb_valid_d = 1'b1;
                        alu_d      = ex_alu_result_i;
                        mread_d    = 1'b0;
                        wb_rd_d    = ex_rd_i;
                        wb_rw_d    = ex_reg_write_i;
                    end else if (ex_mis) begin
                        // Retire without touching memory or the register file
                        wb_valid_d = 1'b1;
                        alu_d      = ex_alu_result_i;
                        mread_d    = 1'b0;
                        wb_rd_d    = ex_rd_i;
                        wb_rw_d    = 1'b0;
                        mis_d      = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        req_d       = 1'b1;
                        cmd_d.we    = ~ex_is_load;
                        cmd_d.addr  = {ex_alu_result_i[XLEN-1:2], 2'b00};
                        cmd_d.wdata = store_wdata(ex_size, ex_store_data_i);
                        cmd_d.be    = ex_is_load ? {BE_W{1'b1}} :
                                      store_be(ex_size, ex_alu_result_i[1:0]);
                        ea_d        = ex_alu_result_i;
                        f3_d        = ex_funct3_i;
                        rd_d        = ex_rd_i;
                        rw_d        = ex_reg_write_i;
                        ld_d        = ex_is_load;
`ifdef MEM_STAGE_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end

            BUSY: begin
                if (dmem_ack_i) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    cmd_d.we   = 1'b0;
                    wb_valid_d = 1'b1;
                    alu_d      = ea_q;
                    mread_d    = ld_q;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = ld_q & rw_q;
                    if (ld_q) begin
                        mdata_d = ext_data;
                    end
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Watchdog abort: retire as a no-write bubble flagged as a bus error
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    cmd_d.we   = 1'b0;
                    wb_valid_d = 1'b1;
                    alu_d      = ea_q;
                    mread_d    = 1'b0;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = 1'b0;
                    berr_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            req_q      <= 1'b0;
            ea_q       <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            ld_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            alu_q      <= '0;
            mdata_q    <= '0;
            mread_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            req_q      <= req_d;
            ea_q       <= ea_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            ld_q       <= ld_d;
            wb_valid_q <= wb_valid_d;
            alu_q      <= alu_d;
            mdata_q    <= mdata_d;
            mread_q    <= mread_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // Watchdog counter and bus-error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            berr_q <= berr_d;
        end
    end

    assign bus_err_o = berr_q;
`else
    assign bus_err_o = 1'b0;
`endif

    assign dmem_req_o     = req_q;
    assign dmem_we_o      = cmd_q.we;
    assign dmem_addr_o    = cmd_q.addr;
    assign dmem_wdata_o   = cmd_q.wdata;
    assign dmem_be_o      = cmd_q.be;
    assign wb_valid_o     = wb_valid_q;
    assign alu_result_o   = alu_q;
    assign mem_data_o     = mdata_q;
    assign mem_read_o     = mread_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_reg_write_o = wb_rw_q;
    assign misalign_err_o = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage. Expected MEM/WB
// records are queued as instructions are driven and popped when wb_valid_o rises.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid_o;
    logic [31:0] alu_result_o;
    logic [31:0] mem_data_o;
    logic        mem_read_o;
    logic [4:0]  wb_rd_o;
    logic        wb_reg_write_o;
    logic        misalign_err_o;
    logic        bus_err_o;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mdata;
        logic        mread;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
    mem_access_stage dut (
`endif
        .clk_i           (clk),
        .rst_i           (rst),
        .ex_valid_i      (ex_valid),
        .ex_alu_result_i (ex_alu_result),
        .ex_store_data_i (ex_store_data),
        .ex_mem_read_i   (ex_mem_read),
        .ex_mem_write_i  (ex_mem_write),
        .ex_funct3_i     (ex_funct3),
        .ex_rd_i         (ex_rd),
        .ex_reg_write_i  (ex_reg_write),
        .stall_o         (stall_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_ack_i      (dmem_ack),
        .dmem_rdata_i    (dmem_rdata),
        .wb_valid_o      (wb_valid_o),
        .alu_result_o    (alu_result_o),
        .mem_data_o      (mem_data_o),
        .mem_read_o      (mem_read_o),
        .wb_rd_o         (wb_rd_o),
        .wb_reg_write_o  (wb_reg_write_o),
        .misalign_err_o  (misalign_err_o),
        .bus_err_o       (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, required end of test");
        $fatal(1);
    end

    // Scoreboard: every retirement must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tests_run++;
                if (wb_valid_o) begin
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL wb_unexpected: got wb_valid=1 alu_result=%h, required wb_valid=0",
                                 alu_result_o);
                    end else begin
                        e = sb_q.pop_front();
                        if (alu_result_o !== e.alu || mem_read_o !== e.mread || wb_rd_o !== e.rd ||
                            wb_reg_write_o !== e.rw || misalign_err_o !== e.mis ||
                            bus_err_o !== e.berr || (e.mread && mem_data_o !== e.mdata)) begin
                            tests_failed++;
                            $display("FAIL wb_record: got alu=%h mdata=%h mread=%b rd=%0d rw=%b mis=%b berr=%b, required alu=%h mdata=%h mread=%b rd=%0d rw=%b mis=%b berr=%b",
                                     alu_result_o, mem_data_o, mem_read_o, wb_rd_o, wb_reg_write_o,
                                     misalign_err_o, bus_err_o, e.alu, e.mdata, e.mread, e.rd,
                                     e.rw, e.mis, e.berr);
                        end
                    end
                end else if (misalign_err_o !== 1'b0 || bus_err_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL err_pulse_idle: got misalign=%b bus_err=%b with wb_valid=0, required 0 0",
                             misalign_err_o, bus_err_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid      = 1'b0;
        ex_alu_result = 32'h0;
        ex_store_data = 32'h0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        ex_clear();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        tests_run++;
        if ({wb_valid_o, dmem_req_o, dmem_we_o, mem_read_o, wb_reg_write_o,
             misalign_err_o, bus_err_o, stall_o} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid/req/we/mread/rw/mis/berr/stall=%b, required 00000000",
                     {wb_valid_o, dmem_req_o, dmem_we_o, mem_read_o, wb_reg_write_o,
                      misalign_err_o, bus_err_o, stall_o});
        end
        tests_run++;
        if (dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || dmem_be_o !== 4'h0 ||
            alu_result_o !== 32'h0 || mem_data_o !== 32'h0 || wb_rd_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%h wdata=%h be=%b alu=%h mdata=%h rd=%0d, required all zero",
                     dmem_addr_o, dmem_wdata_o, dmem_be_o, alu_result_o, mem_data_o, wb_rd_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_alu_op(input logic [31:0] alu, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_alu_result = alu;
        ex_rd         = rd;
        ex_reg_write  = 1'b1;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        sb_q.push_back('{alu, 32'h0, 1'b0, rd, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        tests_run++;
        if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_issue: got stall=%b req=%b, required 0 0", stall_o, dmem_req_o);
        end
        tick();
        ex_clear();
        @(negedge clk);
        tests_run++;
        if (stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_retire: got stall=%b req=%b, required 0 0", stall_o, dmem_req_o);
        end
        tick();
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_data,
                             input int lat, input logic both);
        logic [31:0] waddr;
        waddr         = {addr[31:2], 2'b00};
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = both;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = 32'hA5A5_A5A5;
        ex_rd         = 5'd7;
        ex_reg_write  = 1'b1;
        sb_q.push_back('{addr, exp_data, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        tests_run++;
        if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_accept: got stall=%b req=%b, required 1 0", name, stall_o, dmem_req_o);
        end
        tick();
        for (int k = 1; k <= lat; k++) begin
            dmem_ack   = (k == lat);
            dmem_rdata = (k == lat) ? rdata : 32'hDEAD_0000;
            @(negedge clk);
            tests_run++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== waddr ||
                stall_o !== (k != lat)) begin
                tests_failed++;
                $display("FAIL %s_busy%0d: got req=%b we=%b addr=%h stall=%b, required 1 0 %h %b",
                         name, k, dmem_req_o, dmem_we_o, dmem_addr_o, stall_o, waddr, (k != lat));
            end
            tick();
        end
        dmem_ack = 1'b0;
        ex_clear();
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: got req=%b stall=%b, required 0 0", name, dmem_req_o, stall_o);
        end
        tick();
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        logic [31:0] waddr;
        waddr         = {addr[31:2], 2'b00};
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b1;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = data;
        ex_rd         = 5'd9;
        ex_reg_write  = 1'b1;
        sb_q.push_back('{addr, 32'h0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        tests_run++;
        if (stall_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_accept: got stall=%b, required 1", name, stall_o);
        end
        tick();
        for (int k = 1; k <= 2; k++) begin
            dmem_ack = (k == 2);
            @(negedge clk);
            tests_run++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== waddr ||
                dmem_be_o !== exp_be || dmem_wdata_o !== exp_wdata) begin
                tests_failed++;
                $display("FAIL %s_busy%0d: got req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 %h %b %h",
                         name, k, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                         waddr, exp_be, exp_wdata);
            end
            tick();
        end
        dmem_ack = 1'b0;
        ex_clear();
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: got req=%b, required 0", name, dmem_req_o);
        end
        tick();
    endtask

    task automatic test_misaligned(input string name, input logic is_load, input logic [2:0] f3,
                                   input logic [31:0] addr);
        ex_valid      = 1'b1;
        ex_mem_read   = is_load;
        ex_mem_write  = ~is_load;
        ex_funct3     = f3;
        ex_alu_result = addr;
        ex_store_data = 32'h1111_2222;
        ex_rd         = 5'd11;
        ex_reg_write  = 1'b1;
        sb_q.push_back('{addr, 32'h0, 1'b0, 5'd11, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        tests_run++;
        if (stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_stall: got stall=%b, required 0", name, stall_o);
        end
        tick();
        // Follow-on ALU op enters immediately and retires one cycle later
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_alu_result = 32'h0000_0ABC;
        ex_rd         = 5'd12;
        sb_q.push_back('{32'h0000_0ABC, 32'h0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_noreq: got req=%b stall=%b, required 0 0", name, dmem_req_o, stall_o);
        end
        tick();
        ex_clear();
        @(negedge clk);
        tick();
    endtask

    task automatic test_back_to_back();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_funct3     = 3'b010;
        ex_alu_result = 32'h0000_0700;
        ex_rd         = 5'd3;
        ex_reg_write  = 1'b1;
        sb_q.push_back('{32'h0000_0700, 32'h1357_9BDF, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        tick();
        // Ack in the very first request cycle; EX/MEM still holds the load
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b1 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ack: got req=%b stall=%b, required 1 0", dmem_req_o, stall_o);
        end
        tick();
        dmem_ack      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_alu_result = 32'h0000_55AA;
        ex_rd         = 5'd4;
        sb_q.push_back('{32'h0000_55AA, 32'h0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_next: got req=%b stall=%b, required 0 0", dmem_req_o, stall_o);
        end
        tick();
        ex_clear();
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset_busy();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_funct3     = 3'b010;
        ex_alu_result = 32'h0000_0400;
        ex_rd         = 5'd8;
        ex_reg_write  = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstbusy_req: got req=%b, required 1", dmem_req_o);
        end
        tick();
        rst = 1'b1;
        ex_clear();
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstbusy_idle: got req=%b stall=%b wb_valid=%b, required 0 0 0",
                     dmem_req_o, stall_o, wb_valid_o);
        end
        tick();
        // Late ack for the killed access must be ignored
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstbusy_lateack: got wb_valid=%b req=%b, required 0 0", wb_valid_o, dmem_req_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_funct3     = 3'b010;
        ex_alu_result = 32'h0000_0500;
        ex_rd         = 5'd13;
        ex_reg_write  = 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
        sb_q.push_back('{32'h0000_0500, 32'h0, 1'b0, 5'd13, 1'b0, 1'b0, 1'b1});
        tick();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL timeout_busy%0d: got req=%b stall=%b, required 1 1", k, dmem_req_o, stall_o);
            end
            tick();
        end
        ex_clear();
        @(negedge clk);
        tests_run++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || bus_err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_abort: got req=%b stall=%b bus_err=%b, required 0 0 1",
                     dmem_req_o, stall_o, bus_err_o);
        end
        tick();
`else
        sb_q.push_back('{32'h0000_0500, 32'h0000_00FF, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0});
        tick();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tests_run++;
            if (dmem_req_o !== 1'b1 || stall_o !== 1'b1 || bus_err_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL nowatchdog_wait%0d: got req=%b stall=%b bus_err=%b, required 1 1 0",
                         k, dmem_req_o, stall_o, bus_err_o);
            end
            tick();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_00FF;
        tick();
        dmem_ack = 1'b0;
        ex_clear();
        @(negedge clk);
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_alu_op(32'h0000_1234, 5'd5);
        test_alu_op(32'hFFFF_0001, 5'd31);
        test_load("lb",   3'b000, 32'h0000_0103, 32'h80FF_FF7F, 32'hFFFF_FF80, 3, 1'b0);
        test_load("lbu",  3'b100, 32'h0000_0103, 32'h80FF_FF7F, 32'h0000_0080, 3, 1'b0);
        test_load("lh",   3'b001, 32'h0000_0102, 32'h80FF_FF7F, 32'hFFFF_80FF, 2, 1'b0);
        test_load("lhu",  3'b101, 32'h0000_0102, 32'h80FF_FF7F, 32'h0000_80FF, 1, 1'b0);
        test_load("lhlo", 3'b001, 32'h0000_0100, 32'h80FF_FF7F, 32'hFFFF_FF7F, 2, 1'b0);
        test_load("lb0",  3'b000, 32'h0000_0100, 32'h80FF_FF7F, 32'h0000_007F, 1, 1'b0);
        test_load("lw",   3'b010, 32'h0000_0100, 32'h80FF_FF7F, 32'h80FF_FF7F, 2, 1'b0);
        test_load("f3x",  3'b011, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678, 1, 1'b0);
        test_load("both", 3'b100, 32'h0000_0101, 32'h80FF_FF7F, 32'h0000_00FF, 2, 1'b1);
        test_store("sh",  3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb1", 3'b000, 32'h0000_0201, 32'h1234_5678, 4'b0010, 32'h7878_7878);
        test_store("sb3", 3'b000, 32'h0000_0203, 32'h1234_5678, 4'b1000, 32'h7878_7878);
        test_store("sh0", 3'b001, 32'h0000_0200, 32'h1234_5678, 4'b0011, 32'h5678_5678);
        test_store("sw",  3'b010, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        test_misaligned("mis_lw",  1'b1, 3'b010, 32'h0000_0301);
        test_misaligned("mis_lh",  1'b1, 3'b001, 32'h0000_0303);
        test_misaligned("mis_lhu", 1'b1, 3'b101, 32'h0000_0301);
        test_misaligned("mis_sw",  1'b0, 3'b010, 32'h0000_0302);
        test_misaligned("mis_sh",  1'b0, 3'b001, 32'h0000_0205);
        test_back_to_back();
        test_reset_busy();
        test_timeout();
        repeat (3) tick();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: got %0d retirements still pending, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
